// File: rtl/snes_pad_responder.sv
// snes_pad_responder: device-side SNES pad; latches a 16-bit active-low word and shifts it out MSB first on joy_data.
// Define SNESPAD_TIMEOUT_EN to abandon an unfinished frame after TIMEOUT idle mclk cycles.
module snes_pad_responder #(
    parameter bit FILL_BIT = 1'b0,
    parameter int TIMEOUT  = 21500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] buttons,
    input  logic        joy_strb,
    input  logic        joy_clk,
    output logic        joy_data,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun,
    output logic [15:0] snapshot
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic strb_m, strb_s, strb_d, clk_m, clk_s, clk_d;
    logic strb_rise, clk_rise, timed_out, overrun_n;
    logic [15:0] sr, sr_n, snapshot_n;
    logic [4:0] bcnt, bcnt_n;
    assign strb_rise  = strb_s & ~strb_d;
    assign clk_rise   = clk_s & ~clk_d;
    assign joy_data   = sr[15];
    assign busy       = state == LOAD || state == SHIFT;
    assign frame_done = state == SHIFT && bcnt == 5'd16;
`ifdef SNESPAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic framing;
    assign framing   = state == SHIFT || state == DONE;
    assign timed_out = framing && !clk_rise && tcnt == TW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (reset || clk_rise || !framing)
            tcnt <= '0;
        else
            tcnt <= tcnt + TW'(1);
    end
`else
    assign timed_out = 1'b0;
`endif
    always_comb begin
        state_n    = state;
        sr_n       = sr;
        bcnt_n     = bcnt;
        overrun_n  = overrun;
        snapshot_n = snapshot;
        // the latch wins over any clock edge seen in the same cycle
        if (strb_s) begin
            state_n   = LOAD;
            sr_n      = buttons;
            bcnt_n    = '0;
            overrun_n = strb_rise ? 1'b0 : overrun;
        end else if (timed_out) begin
            state_n = IDLE;
            sr_n    = '1;
        end else if (state == LOAD) begin
            state_n    = SHIFT;
            snapshot_n = buttons;
        end else if (state == SHIFT || state == DONE) begin
            if (clk_rise) begin
                sr_n      = {sr[14:0], FILL_BIT};
                bcnt_n    = bcnt == 5'd16 ? bcnt : bcnt + 5'd1;
                overrun_n = overrun | (bcnt == 5'd16);
            end
            state_n = bcnt == 5'd16 ? DONE : state;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            {strb_m, strb_s, strb_d} <= 3'b000;
            {clk_m, clk_s, clk_d}    <= 3'b111;
            state    <= IDLE;
            sr       <= '1;
            bcnt     <= '0;
            overrun  <= 1'b0;
            snapshot <= '1;
        end else begin
            {strb_m, strb_s, strb_d} <= {joy_strb, strb_m, strb_s};
            {clk_m, clk_s, clk_d}    <= {joy_clk, clk_m, clk_s};
            state    <= state_n;
            sr       <= sr_n;
            bcnt     <= bcnt_n;
            overrun  <= overrun_n;
            snapshot <= snapshot_n;
        end
    end
endmodule
